dc_upload: RTL and testbench

- Transmit-side counterpart of the data-cache download path inside the communication assist.
- Accepts one complete outgoing message from the data cache: up to 9 flits of 16 bits, 144 bits total, with an explicit flit count.
- Requests the OUT-side arbiter, then serializes the message flit by flit into the OUT fifo with head/body/tail control codes.
- Exposes its FSM state to the arbiter so the arbiter knows when a message is pending or in flight.

---
 rtl/dc_upload_pkg.sv | 40 ++++
 rtl/dc_upload_flit_sel.sv | 27 ++
 rtl/dc_upload.sv | 120 ++++++++++++
 tb/tb_dc_upload.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_upload_pkg.sv
// Shared definitions for the communication-assist upload/download paths:
// flit control codes, upload FSM encoding, reply commands and length clamping.
package dc_upload_pkg;

    localparam int MAX_FLITS = 9;
    localparam int FLIT_W    = 16;
    localparam int MSG_W     = MAX_FLITS * FLIT_W;

    localparam logic [3:0] MAX_LEN = 4'd9;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b10;
    localparam logic [1:0] TAIL = 2'b11;

    typedef enum logic [1:0] {
        UP_IDLE = 2'b00,
        UP_REQ  = 2'b01,
        UP_BUSY = 2'b10
    } upload_state_t;

    // Reply commands shared with the download side.
    localparam logic [4:0] CMD_RD_REPLY      = 5'b00001;
    localparam logic [4:0] CMD_WR_REPLY      = 5'b00010;
    localparam logic [4:0] CMD_INV_REPLY     = 5'b00011;
    localparam logic [4:0] CMD_FLUSH_REPLY   = 5'b00100;
    localparam logic [4:0] CMD_SHARED_REPLY  = 5'b00101;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        logic [3:0] res;
        if (len == 4'd0) begin
            res = 4'd1;
        end else if (len > MAX_LEN) begin
            res = MAX_LEN;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/dc_upload_flit_sel.sv
// 9:1 flit selector over a 144-bit message; out-of-range selects give zero.
module flit_sel_9to1
    import dc_upload_pkg::*;
(
    input  logic [MSG_W-1:0]  msg,
    input  logic [3:0]        sel,
    output logic [FLIT_W-1:0] flit
);

    // Select flit number sel (0 = lowest 16 bits).
    always_comb begin
        flit = 16'h0000;
        case (sel)
            4'd0:    flit = msg[15:0];
            4'd1:    flit = msg[31:16];
            4'd2:    flit = msg[47:32];
            4'd3:    flit = msg[63:48];
            4'd4:    flit = msg[79:64];
            4'd5:    flit = msg[95:80];
            4'd6:    flit = msg[111:96];
            4'd7:    flit = msg[127:112];
            4'd8:    flit = msg[143:128];
            default: flit = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dc_upload.sv
// Data-cache upload path: captures one outgoing message, requests the OUT
// arbiter, then serializes it flit by flit into the OUT fifo.
module dc_upload
    import dc_upload_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              v_dc_upload,
    input  logic [MSG_W-1:0]  dc_upload_flits,
    input  logic [3:0]        dc_upload_len,
    output logic              dc_upload_ack,
    input  logic              upload_grant,
    input  logic              out_rdy,
    output logic              v_flit_out,
    output logic [FLIT_W-1:0] flit_out,
    output logic [1:0]        flit_ctrl_out,
    output logic [1:0]        dc_upload_state
);

    upload_state_t     r_state;
    logic [3:0]        r_cnt;
    logic [3:0]        r_len;
    logic [MSG_W-1:0]  r_msg;

    upload_state_t     w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [3:0]        w_len_nxt;
    logic [MSG_W-1:0]  w_msg_nxt;
    logic              w_ack;
    logic              w_v_flit;
    logic [1:0]        w_ctrl;
    logic              w_last;
    logic [FLIT_W-1:0] w_flit;

    flit_sel_9to1 u_flit_sel (
        .msg  (r_msg),
        .sel  (r_cnt),
        .flit (w_flit)
    );

    assign w_last = (r_cnt == (r_len - 4'd1));

    // State, counter, length and message registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UP_IDLE;
            r_cnt   <= 4'd0;
            r_len   <= 4'd0;
            r_msg   <= {MSG_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_msg   <= w_msg_nxt;
        end
    end

    // Next-state logic and flit/handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_msg_nxt   = r_msg;
        w_ack       = 1'b0;
        w_v_flit    = 1'b0;
        w_ctrl      = 2'b00;
        case (r_state)
            UP_IDLE: begin
                w_ack = v_dc_upload;
                if (v_dc_upload) begin
                    w_msg_nxt   = dc_upload_flits;
                    w_len_nxt   = clamp_len(dc_upload_len);
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = UP_REQ;
                end else begin
                    w_state_nxt = UP_IDLE;
                end
            end
            UP_REQ: begin
                if (upload_grant) begin
                    w_state_nxt = UP_BUSY;
                end else begin
                    w_state_nxt = UP_REQ;
                end
            end
            UP_BUSY: begin
                w_v_flit = 1'b1;
                if (w_last) begin
                    w_ctrl = TAIL;
                end else if (r_cnt == 4'd0) begin
                    w_ctrl = HEAD;
                end else begin
                    w_ctrl = BODY;
                end
                // A stalled flit keeps cnt, so the same flit/ctrl stay on the bus.
                if (out_rdy && w_last) begin
                    w_state_nxt = UP_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_len_nxt   = 4'd0;
                end else if (out_rdy) begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end else begin
                    w_state_nxt = UP_BUSY;
                end
            end
            default: begin
                w_state_nxt = UP_IDLE;
                w_cnt_nxt   = 4'd0;
                w_len_nxt   = 4'd0;
            end
        endcase
    end

    assign dc_upload_ack   = w_ack & ~rst;
    assign v_flit_out      = w_v_flit & ~rst;
    assign flit_out        = (w_v_flit && !rst) ? w_flit : 16'h0000;
    assign flit_ctrl_out   = rst ? 2'b00 : w_ctrl;
    assign dc_upload_state = r_state;

endmodule

// File: tb/tb_dc_upload.sv
// Self-checking bench for dc_upload: directed table, randomized messages
// against a queue-based reference model, and a mid-message reset sequence.
module tb_dc_upload;

    logic         clk = 1'b0;
    logic         rst;
    logic         v_dc_upload;
    logic [143:0] dc_upload_flits;
    logic [3:0]   dc_upload_len;
    logic         dc_upload_ack;
    logic         upload_grant;
    logic         out_rdy;
    logic         v_flit_out;
    logic [15:0]  flit_out;
    logic [1:0]   flit_ctrl_out;
    logic [1:0]   dc_upload_state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dc_upload dut (
        .clk             (clk),
        .rst             (rst),
        .v_dc_upload     (v_dc_upload),
        .dc_upload_flits (dc_upload_flits),
        .dc_upload_len   (dc_upload_len),
        .dc_upload_ack   (dc_upload_ack),
        .upload_grant    (upload_grant),
        .out_rdy         (out_rdy),
        .v_flit_out      (v_flit_out),
        .flit_out        (flit_out),
        .flit_ctrl_out   (flit_ctrl_out),
        .dc_upload_state (dc_upload_state)
    );

    typedef struct {
        logic [15:0] flit;
        logic [1:0]  ctrl;
    } flit_t;

    typedef struct {
        logic [3:0]  len;
        logic [15:0] base;
        int          gd;
        int          rdy_mode;
        bit          hold_v;
        int          exp_n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] make_msg(input logic [15:0] base);
        logic [143:0] m;
        for (int k = 0; k < 9; k++) begin
            m[k*16 +: 16] = base + 16'(k + 1);
        end
        return m;
    endfunction

    function automatic logic [143:0] rand_msg();
        logic [143:0] m;
        for (int k = 0; k < 9; k++) begin
            m[k*16 +: 16] = 16'($urandom);
        end
        return m;
    endfunction

    // Sends one message and checks timing, handshakes and the flit stream.
    // rdy_mode: 0 always ready, 1 random ready, 2 stall 4 cycles on flit 2.
    task automatic run_msg(input logic [3:0] len_in, input logic [143:0] msg, input int gd,
                           input int rdy_mode, input bit hold_v, input int exp_n, input string tag);
        flit_t       exp_q[$];
        flit_t       got[$];
        flit_t       e;
        int          n, c, first_c, stalls, stall_run;
        bit          prev_stall, done;
        logic [15:0] prev_flit;
        logic [1:0]  prev_ctrl;

        n = (len_in == 4'd0) ? 1 : ((len_in > 4'd9) ? 9 : int'(len_in));
        for (int k = 0; k < n; k++) begin
            e.flit = msg[k*16 +: 16];
            e.ctrl = (k == n - 1) ? 2'b11 : ((k == 0) ? 2'b01 : 2'b10);
            exp_q.push_back(e);
        end

        v_dc_upload     = 1'b1;
        dc_upload_flits = msg;
        dc_upload_len   = len_in;
        upload_grant    = (gd == 0);
        out_rdy         = 1'b1;
        @(negedge clk);
        chk({tag, "_ack"}, 32'(dc_upload_ack), 32'd1);
        chk({tag, "_idle0"}, 32'(dc_upload_state), 32'd0);
        @(posedge clk); #1;
        dc_upload_flits = rand_msg();
        dc_upload_len   = 4'($urandom);
        v_dc_upload     = hold_v;

        c = 1; first_c = -1; stalls = 0; stall_run = 0;
        prev_stall = 1'b0; done = 1'b0; prev_flit = 16'h0; prev_ctrl = 2'b00;
        while (!done && c < 200) begin
            upload_grant = (c >= 1 + gd);
            case (rdy_mode)
                1: out_rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    if (got.size() == 1 && stall_run < 4) begin
                        out_rdy = 1'b0;
                        stall_run++;
                    end else begin
                        out_rdy = 1'b1;
                    end
                end
                default: out_rdy = 1'b1;
            endcase
            @(negedge clk);
            if (c < 2 + gd) begin
                chk({tag, "_req_state"}, 32'(dc_upload_state), 32'd1);
                chk({tag, "_req_noflit"}, 32'(v_flit_out), 32'd0);
            end else if (dc_upload_state == 2'b00) begin
                done = 1'b1;
                chk({tag, "_idle_noflit"}, 32'(v_flit_out), 32'd0);
            end else begin
                chk({tag, "_busy_state"}, 32'(dc_upload_state), 32'd2);
                chk({tag, "_busy_v"}, 32'(v_flit_out), 32'd1);
                if (prev_stall) begin
                    chk({tag, "_hold_flit"}, 32'(flit_out), 32'(prev_flit));
                    chk({tag, "_hold_ctrl"}, 32'(flit_ctrl_out), 32'(prev_ctrl));
                end
                if (first_c < 0) first_c = c;
                if (out_rdy) begin
                    e.flit = flit_out;
                    e.ctrl = flit_ctrl_out;
                    got.push_back(e);
                end else begin
                    stalls++;
                end
                prev_stall = !out_rdy;
                prev_flit  = flit_out;
                prev_ctrl  = flit_ctrl_out;
            end
            if (hold_v && !done) begin
                chk({tag, "_no_ack_busy"}, 32'(dc_upload_ack), 32'd0);
            end
            if (!done) begin
                @(posedge clk); #1;
                c++;
            end
        end
        v_dc_upload  = 1'b0;
        upload_grant = 1'b0;
        out_rdy      = 1'b1;

        if (!done) begin
            n_total++;
            $display("FAIL %s_timeout: got no return to idle within %0d cycles, expected idle", tag, c);
        end else begin
            chk({tag, "_first_cyc"}, 32'(first_c), 32'(2 + gd));
            chk({tag, "_idle_cyc"}, 32'(c), 32'(first_c + n + stalls));
        end
        chk({tag, "_nflits"}, 32'(got.size()), 32'(n));
        if (exp_n >= 0) chk({tag, "_tbl_n"}, 32'(got.size()), 32'(exp_n));
        for (int k = 0; k < n && k < got.size(); k++) begin
            chk($sformatf("%s_flit%0d", tag, k + 1), 32'(got[k].flit), 32'(exp_q[k].flit));
            chk($sformatf("%s_ctrl%0d", tag, k + 1), 32'(got[k].ctrl), 32'(exp_q[k].ctrl));
        end
        @(posedge clk); #1;
    endtask

    vec_t        vecs[7];
    logic [143:0] m;

    initial begin
        rst             = 1'b1;
        v_dc_upload     = 1'b1;
        dc_upload_flits = 144'h0;
        dc_upload_len   = 4'd1;
        upload_grant    = 1'b1;
        out_rdy         = 1'b1;

        vecs[0] = '{len: 4'd1,  base: 16'h029F, gd: 0, rdy_mode: 0, hold_v: 1'b0, exp_n: 1};
        vecs[1] = '{len: 4'd9,  base: 16'h1000, gd: 0, rdy_mode: 0, hold_v: 1'b0, exp_n: 9};
        vecs[2] = '{len: 4'd3,  base: 16'h2000, gd: 0, rdy_mode: 2, hold_v: 1'b0, exp_n: 3};
        vecs[3] = '{len: 4'd4,  base: 16'h5000, gd: 5, rdy_mode: 0, hold_v: 1'b0, exp_n: 4};
        vecs[4] = '{len: 4'd2,  base: 16'h6000, gd: 1, rdy_mode: 0, hold_v: 1'b1, exp_n: 2};
        vecs[5] = '{len: 4'd0,  base: 16'h7000, gd: 0, rdy_mode: 0, hold_v: 1'b0, exp_n: 1};
        vecs[6] = '{len: 4'd15, base: 16'h8000, gd: 0, rdy_mode: 0, hold_v: 1'b0, exp_n: 9};

        // Reset: outputs forced low even with a request pending.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ack", 32'(dc_upload_ack), 32'd0);
        chk("rst_v", 32'(v_flit_out), 32'd0);
        chk("rst_flit", 32'(flit_out), 32'd0);
        chk("rst_ctrl", 32'(flit_ctrl_out), 32'd0);
        chk("rst_state", 32'(dc_upload_state), 32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        v_dc_upload = 1'b0;
        @(negedge clk);
        chk("post_rst_state", 32'(dc_upload_state), 32'd0);
        chk("post_rst_v", 32'(v_flit_out), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_msg(vecs[i].len, make_msg(vecs[i].base), vecs[i].gd, vecs[i].rdy_mode,
                    vecs[i].hold_v, vecs[i].exp_n, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            run_msg(4'($urandom_range(0, 15)), rand_msg(), int'($urandom_range(0, 3)), 1,
                    1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", i));
        end

        // Reset while flit 5 of 6 is on the bus.
        m               = make_msg(16'h3000);
        v_dc_upload     = 1'b1;
        dc_upload_flits = m;
        dc_upload_len   = 4'd6;
        upload_grant    = 1'b1;
        out_rdy         = 1'b1;
        @(posedge clk); #1;
        v_dc_upload = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("rb_flit%0d", c - 1), 32'(flit_out), 32'(16'h3000 + 16'(c - 1)));
                chk($sformatf("rb_ctrl%0d", c - 1), 32'(flit_ctrl_out), (c == 2) ? 32'd1 : 32'd2);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rb_during_v", 32'(v_flit_out), 32'd0);
        chk("rb_during_flit", 32'(flit_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rb_after_state", 32'(dc_upload_state), 32'd0);
        chk("rb_after_v", 32'(v_flit_out), 32'd0);
        chk("rb_after_flit", 32'(flit_out), 32'd0);
        chk("rb_after_ctrl", 32'(flit_ctrl_out), 32'd0);
        chk("rb_after_ack", 32'(dc_upload_ack), 32'd0);
        @(posedge clk); #1;
        run_msg(4'd2, make_msg(16'h4000), 0, 0, 1'b0, 2, "rb_new");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
